// File: rtl/iagc_pkg.sv
// -----------------------------------------------------------------------------
// iagc_pkg
// Shared definitions for the IAGC host byte protocol blocks: status encodings,
// the dump header byte, the dump transmitter FSM state type and the
// bytes-per-word helper.
// No ports (package).
// -----------------------------------------------------------------------------
package iagc_pkg;

  // IAGC status encodings reported to the host
  typedef enum logic [1:0] {
    IAGC_ST_IDLE = 2'd0,
    IAGC_ST_BUSY = 2'd1,
    IAGC_ST_DONE = 2'd2,
    IAGC_ST_ERR  = 2'd3
  } iagc_status_e;

  // First byte of every memory dump
  localparam logic [7:0] DUMP_HEADER = 8'hA5;

  // Dump transmitter FSM states
  typedef enum logic [3:0] {
    DS_IDLE     = 4'd0,
    DS_HDR      = 4'd1,
    DS_HDR_WAIT = 4'd2,
    DS_RD_REQ   = 4'd3,
    DS_RD_WAIT  = 4'd4,
    DS_SEND     = 4'd5,
    DS_TX_WAIT  = 4'd6,
    DS_NEXT     = 4'd7,
    DS_CHK      = 4'd8,
    DS_CHK_WAIT = 4'd9,
    DS_FIN      = 4'd10
  } dump_state_e;

  // Number of DATA_SIZE bytes carried by one WORD_SIZE memory word
  function automatic int unsigned bpw(input int unsigned word_size,
                                      input int unsigned data_size);
    return word_size / data_size;
  endfunction

endpackage

// File: rtl/dump_tx_unit_word_byte_splitter.sv
// -----------------------------------------------------------------------------
// word_byte_splitter
// Holds one memory word and presents it MSB byte first; each advance shifts
// the next byte into the top position.
// Ports:
//   i_clock, i_reset   clock / synchronous active-high reset
//   i_load, i_word     load a new word (byte index returns to 0)
//   i_advance          move to the next byte
//   o_byte             current (most significant remaining) byte
//   o_last             current byte is the final byte of the word
// -----------------------------------------------------------------------------
module word_byte_splitter
  import iagc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [WORD_SIZE-1:0] i_word,
  input  logic                 i_advance,
  output logic [DATA_SIZE-1:0] o_byte,
  output logic                 o_last
);

  localparam int unsigned BPW   = bpw(WORD_SIZE, DATA_SIZE);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WORD_SIZE-1:0] word_q;
  logic [IDX_W-1:0]     idx_q;

  // Word shift register and byte index
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_load) begin
      word_q <= i_word;
      idx_q  <= '0;
    end else if (i_advance) begin
      word_q <= word_q << DATA_SIZE;
      idx_q  <= idx_q + IDX_W'(1);
    end else begin
      word_q <= word_q;
      idx_q  <= idx_q;
    end
  end

  assign o_byte = word_q[WORD_SIZE-1 -: DATA_SIZE];
  assign o_last = (idx_q == IDX_W'(BPW - 1));

endmodule

// File: rtl/dump_tx_unit.sv
// -----------------------------------------------------------------------------
// dump_tx_unit
// On a dump request, sends header 8'hA5 to the UART followed by sample memory
// words 0..last_addr, each split into bytes MSB first.
// Optional feature macro: DUMP_TX_CHECKSUM_EN -- appends the XOR of all data
// bytes (header excluded) as a final byte.
// Ports:
//   i_clock, i_reset        clock / synchronous active-high reset
//   i_start, i_last_addr    dump request and last address (sampled on start)
//   o_mem_rd_en, o_mem_addr memory read strobe / address
//   i_mem_data              read data, valid one cycle after o_mem_rd_en
//   o_tx_data, o_tx_start   byte and launch pulse to UART TX
//   i_tx_done               UART byte-complete pulse
//   o_busy, o_done          dump in progress / completion pulse
// All outputs are registers.
// -----------------------------------------------------------------------------
module dump_tx_unit
  import iagc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_SIZE-1:0] i_last_addr,
  output logic                 o_mem_rd_en,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  output logic [DATA_SIZE-1:0] o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic                 o_done
);

  dump_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] last_q, last_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 split_load, split_adv, split_last;
  logic [DATA_SIZE-1:0] split_byte;
`ifdef DUMP_TX_CHECKSUM_EN
  logic [DATA_SIZE-1:0] chk_q, chk_d;
`endif

  word_byte_splitter #(
    .WORD_SIZE(WORD_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) u_splitter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (split_load),
    .i_word   (i_mem_data),
    .i_advance(split_adv),
    .o_byte   (split_byte),
    .o_last   (split_last)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    split_load = 1'b0;
    split_adv  = 1'b0;
`ifdef DUMP_TX_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      DS_IDLE: begin
        if (i_start) begin
          last_d  = i_last_addr;
          addr_d  = '0;
`ifdef DUMP_TX_CHECKSUM_EN
          chk_d   = '0;
`endif
          state_d = DS_HDR;
        end else begin
          state_d = DS_IDLE;
        end
      end
      DS_HDR: begin
        tx_data_d  = DATA_SIZE'(DUMP_HEADER);
        tx_start_d = 1'b1;
        state_d    = DS_HDR_WAIT;
      end
      DS_HDR_WAIT: begin
        if (i_tx_done) begin
          state_d = DS_RD_REQ;
        end else begin
          state_d = DS_HDR_WAIT;
        end
      end
      DS_RD_REQ: begin
        state_d = DS_RD_WAIT;
      end
      DS_RD_WAIT: begin
        split_load = 1'b1;
        state_d    = DS_SEND;
      end
      DS_SEND: begin
        tx_data_d  = split_byte;
        tx_start_d = 1'b1;
`ifdef DUMP_TX_CHECKSUM_EN
        chk_d      = chk_q ^ split_byte;
`endif
        state_d    = DS_TX_WAIT;
      end
      DS_TX_WAIT: begin
        if (i_tx_done) begin
          split_adv = 1'b1;
          state_d   = split_last ? DS_NEXT : DS_SEND;
        end else begin
          state_d = DS_TX_WAIT;
        end
      end
      DS_NEXT: begin
        // Compare before increment so last_addr = all-ones never wraps
        if (addr_q == last_q) begin
`ifdef DUMP_TX_CHECKSUM_EN
          state_d = DS_CHK;
`else
          state_d = DS_FIN;
`endif
        end else begin
          addr_d  = addr_q + ADDR_SIZE'(1);
          state_d = DS_RD_REQ;
        end
      end
`ifdef DUMP_TX_CHECKSUM_EN
      DS_CHK: begin
        tx_data_d  = chk_q;
        tx_start_d = 1'b1;
        state_d    = DS_CHK_WAIT;
      end
      DS_CHK_WAIT: begin
        if (i_tx_done) begin
          state_d = DS_FIN;
        end else begin
          state_d = DS_CHK_WAIT;
        end
      end
`endif
      DS_FIN: begin
        state_d = DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
    // Strobes are decoded from the next state so they line up with it
    rd_en_d = (state_d == DS_RD_REQ);
    busy_d  = (state_d != DS_IDLE) && (state_d != DS_FIN);
    done_d  = (state_d == DS_FIN);
  end

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= DS_IDLE;
      last_q     <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_TX_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DUMP_TX_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign o_mem_rd_en = rd_en_q;
  assign o_mem_addr  = addr_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_dump_tx_unit.sv
// -----------------------------------------------------------------------------
// tb_dump_tx_unit
// Directed bench for dump_tx_unit (DATA=8, WORD=16, ADDR=2): memory and UART
// responder models, byte/read logging and hand-computed expected streams.
// -----------------------------------------------------------------------------
module tb_dump_tx_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start;
  logic [1:0]  i_last_addr;
  logic        o_mem_rd_en;
  logic [1:0]  o_mem_addr;
  logic [15:0] i_mem_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy, o_done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [4];
  logic [7:0]  tx_q [$];
  logic [1:0]  rd_q [$];
  int          done_cnt  = 0;
  int          uart_cnt  = 0;
  logic [7:0]  cur_byte  = 8'h00;
  logic        uart_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        spur_next = 1'b0;
  logic        inject_spur = 1'b0;
  logic        pend = 1'b0;
  logic [1:0]  pend_addr = 2'd0;

  always #5 clk = ~clk;

  assign i_tx_done = uart_done | spur_done;

  dump_tx_unit #(
    .DATA_SIZE(8),
    .WORD_SIZE(16),
    .ADDR_SIZE(2)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_last_addr(i_last_addr),
    .o_mem_rd_en(o_mem_rd_en),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // UART transmitter model: logs launched bytes, answers with a done pulse
  always @(negedge clk) begin
    uart_done = 1'b0;
    if (i_reset) begin
      uart_cnt = 0;
    end else if (o_tx_start) begin
      check_eq("tx_start_before_done", 32'(uart_cnt), 32'd0);
      tx_q.push_back(o_tx_data);
      cur_byte = o_tx_data;
      uart_cnt = 3;
    end else if (uart_cnt != 0) begin
      check_eq("tx_data_stable", 32'(o_tx_data), 32'(cur_byte));
      uart_cnt--;
      if (uart_cnt == 0) uart_done = 1'b1;
    end
  end

  // Memory model (data valid only in the cycle after the strobe), read log,
  // spurious-done injector and o_done monitor
  always @(negedge clk) begin
    i_mem_data = pend ? mem[pend_addr] : 16'hDEAD;
    pend       = o_mem_rd_en;
    pend_addr  = o_mem_addr;
    if (o_mem_rd_en) rd_q.push_back(o_mem_addr);
    spur_done  = spur_next;
    spur_next  = inject_spur & o_mem_rd_en;
    if (o_done) begin
      done_cnt++;
      check_eq("busy_low_at_done", 32'(o_busy), 32'd0);
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rd_en"},    32'(o_mem_rd_en), 32'd0);
    check_eq({tag, "_addr"},     32'(o_mem_addr),  32'd0);
    check_eq({tag, "_tx_data"},  32'(o_tx_data),   32'd0);
    check_eq({tag, "_tx_start"}, 32'(o_tx_start),  32'd0);
    check_eq({tag, "_busy"},     32'(o_busy),      32'd0);
    check_eq({tag, "_done"},     32'(o_done),      32'd0);
  endtask

  task automatic run_dump(input string name, input logic [1:0] last,
                          input logic [7:0] exp [$], input bit extra_start);
    int cyc;
    tx_q.delete();
    rd_q.delete();
    done_cnt    = 0;
    i_last_addr = last;
    i_start     = 1'b1;
    tick(1);
    i_start     = 1'b0;
    i_last_addr = ~last;
    check_eq({name, "_busy_after_start"}, 32'(o_busy), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      tick(1);
      if (extra_start && cyc == 8)  i_start = 1'b1;
      if (extra_start && cyc == 9)  i_start = 1'b0;
      cyc++;
    end
    check_eq({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    tick(4);
    check_eq({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({name, "_busy_end"}, 32'(o_busy), 32'd0);
    check_eq({name, "_byte_count"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", name, i), 32'(tx_q[i]), 32'(exp[i]));
    check_eq({name, "_read_count"}, 32'(rd_q.size()), 32'(last) + 32'd1);
    for (int i = 0; i < rd_q.size(); i++)
      check_eq($sformatf("%s_rd_addr%0d", name, i), 32'(rd_q[i]), 32'(i));
  endtask

  initial begin
    logic [7:0] e1 [$];
    logic [7:0] e2 [$];
    int cyc;
    int sz;
    e1 = {8'hA5, 8'h12, 8'h34};
    e2 = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
`ifdef DUMP_TX_CHECKSUM_EN
    e1.push_back(8'h26);
    e2.push_back(8'h04);
`endif
    i_reset     = 1'b1;
    i_start     = 1'b0;
    i_last_addr = 2'd0;
    mem[0] = 16'h1234; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h0000;
    tick(3);
    check_idle_outputs("reset");
    i_reset = 1'b0;
    tick(2);

    // T1: single word
    run_dump("t1", 2'd0, e1, 1'b0);

    // T2/T4: four words, full 2-bit address space, no wrap
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003; mem[3] = 16'h0004;
    run_dump("t2", 2'd3, e2, 1'b0);
    check_eq("t4_idle_no_extra_read", 32'(o_mem_rd_en), 32'd0);

    // T5: restart attempt and spurious done while dumping
    inject_spur = 1'b1;
    run_dump("t5", 2'd3, e2, 1'b1);
    inject_spur = 1'b0;

    // T6: reset while waiting for a data byte to finish
    tx_q.delete();
    done_cnt    = 0;
    i_last_addr = 2'd3;
    i_start     = 1'b1;
    tick(1);
    i_start = 1'b0;
    cyc = 0;
    while (tx_q.size() < 2 && cyc < 500) begin
      tick(1);
      cyc++;
    end
    check_eq("t6_reached_tx_wait", 32'(tx_q.size()), 32'd2);
    i_reset = 1'b1;
    tick(1);
    check_idle_outputs("t6_reset");
    i_reset = 1'b0;
    sz = tx_q.size();
    tick(20);
    check_eq("t6_no_tx_after_reset", 32'(tx_q.size()), 32'(sz));
    check_eq("t6_no_done_after_reset", 32'(done_cnt), 32'd0);
    mem[0] = 16'h1234;
    run_dump("t6_restart", 2'd0, e1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
